// File: rtl/prior8_arbiter.sv
// ---------------------------------------------------------------------------
// prior8_arbiter: 8-requester grant-and-hold arbiter with one-cycle turnaround.
// Optional ROUND_ROBIN_EN macro replaces fixed priority with a rotating pointer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prior8_arbiter #(
    parameter int MAXHOLD = 15
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic [7:0] GNT,
    output logic [2:0] A,
    output logic       VALID,
    output logic       IDLE,
    output logic       TIMEOUT
);

    localparam int              CW        = $clog2(MAXHOLD + 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      gnt_q, gnt_d;
    logic [2:0]      a_q, a_d;
    logic            valid_q, valid_d;
    logic            idle_q, idle_d;
    logic            timeout_q, timeout_d;
    logic [2:0]      winner;

    // Highest set bit wins; a zero vector yields index 0 (never used for a grant).
    function automatic logic [2:0] prio_enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [2:0] p_q, p_d;
    logic [7:0] req_rot;

    // Rotate so requester P lands on bit 7, encode, then rotate the index back.
    always_comb begin
        req_rot = 8'h00;
        for (int i = 0; i < 8; i++) begin
            req_rot[i] = REQ[3'(i) + p_q + 3'd1];
        end
        winner = prio_enc8(req_rot) + p_q + 3'd1;
    end
`else
    always_comb begin
        winner = prio_enc8(REQ);
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        a_d       = a_q;
        valid_d   = valid_q;
        idle_d    = idle_q;
        timeout_d = 1'b0;
`ifdef ROUND_ROBIN_EN
        p_d       = p_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ != 8'h00) begin
                    state_d = S_GRANT;
                    cnt_d   = '0;
                    gnt_d   = 8'h01 << winner;
                    a_d     = winner;
                    valid_d = 1'b1;
                    idle_d  = 1'b0;
`ifdef ROUND_ROBIN_EN
                    p_d     = winner - 3'd1;
`endif
                end
            end
            S_GRANT: begin
                if (DONE || !REQ[a_q] || (cnt_q == HOLD_LAST)) begin
                    // Normal release takes precedence over expiry in the same cycle.
                    timeout_d = !(DONE || !REQ[a_q]);
                    state_d   = S_GAP;
                    cnt_d     = '0;
                    gnt_d     = 8'h00;
                    a_d       = 3'd0;
                    valid_d   = 1'b0;
                    idle_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                gnt_d   = 8'h00;
                a_d     = 3'd0;
                valid_d = 1'b0;
                idle_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gnt_q     <= 8'h00;
            a_q       <= 3'd0;
            valid_q   <= 1'b0;
            idle_q    <= 1'b1;
            timeout_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            p_q       <= 3'd7;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            a_q       <= a_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
`ifdef ROUND_ROBIN_EN
            p_q       <= p_d;
`endif
        end
    end

    assign GNT     = gnt_q;
    assign A       = a_q;
    assign VALID   = valid_q;
    assign IDLE    = idle_q;
    assign TIMEOUT = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_prior8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prior8_arbiter: directed scoreboard bench for prior8_arbiter (MAXHOLD=4).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prior8_arbiter;

    logic       CLK;
    logic       RESET_L;
    logic [7:0] REQ;
    logic       DONE;
    logic [7:0] GNT;
    logic [2:0] A;
    logic       VALID;
    logic       IDLE;
    logic       TIMEOUT;

    prior8_arbiter #(.MAXHOLD(4)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .A       (A),
        .VALID   (VALID),
        .IDLE    (IDLE),
        .TIMEOUT (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] a;
        logic       valid;
        logic       idle;
        logic       timeout;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] g, input logic [2:0] a,
                        input logic v, input logic t);
        exp_t e;
        e.gnt = g; e.a = a; e.valid = v; e.idle = ~v; e.timeout = t;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        chk({t, ".GNT"},     GNT,            e.gnt);
        chk({t, ".A"},       {5'd0, A},      {5'd0, e.a});
        chk({t, ".VALID"},   {7'd0, VALID},  {7'd0, e.valid});
        chk({t, ".IDLE"},    {7'd0, IDLE},   {7'd0, e.idle});
        chk({t, ".TIMEOUT"}, {7'd0, TIMEOUT},{7'd0, e.timeout});
    endtask

    // Drive one cycle of inputs, record the outputs expected after the next edge.
    task automatic cyc(input logic [7:0] req, input logic done, input logic [7:0] g,
                       input logic [2:0] a, input logic v, input logic t, input string tag);
        @(negedge CLK);
        REQ  = req;
        DONE = done;
        push(tag, g, a, v, t);
        @(posedge CLK);
        #1;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] w;
        logic [7:0] gw;
        logic [2:0] rr_a [4];

        RESET_L = 1'b0;
        REQ     = 8'h00;
        DONE    = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge CLK);
        #1;
        chk("reset.GNT",     GNT,             8'h00);
        chk("reset.A",       {5'd0, A},       8'h00);
        chk("reset.VALID",   {7'd0, VALID},   8'h00);
        chk("reset.IDLE",    {7'd0, IDLE},    8'h01);
        chk("reset.TIMEOUT", {7'd0, TIMEOUT}, 8'h00);
        @(negedge CLK);
        RESET_L = 1'b1;

        // Exhaustive single-request priority check
        for (int r = 1; r < 256; r++) begin
            w = 3'd0;
            for (int b = 0; b < 8; b++) if (r[b]) w = 3'(b);
            gw = 8'h01 << w;
            cyc(8'(r), 1'b0, gw,    w,    1'b1, 1'b0, "exh_grant");
            cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "exh_release");
            cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "exh_gap");
        end

        // DONE pulse on third grant cycle, then lower requester takes over
        cyc(8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "done_g1");
        cyc(8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "done_g2");
        cyc(8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "done_g3");
        cyc(8'h0C, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done_gap");
        cyc(8'h0C, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "done_idle");
        cyc(8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "done_next");
        cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "done_rel");
        cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "done_rel_gap");

        // MAXHOLD expiry with the request held
        for (int k = 0; k < 4; k++)
            cyc(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "hold_grant");
        cyc(8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, "hold_timeout");
        cyc(8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "hold_dead2");
        cyc(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "hold_regrant");

        // Same-cycle DONE and request drop is a normal release
        cyc(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "both_release");
        cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "both_gap");

        // Asynchronous reset mid-grant
        cyc(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "arst_grant");
        #2;
        RESET_L = 1'b0;
        REQ     = 8'h00;
        #1;
        chk("arst.GNT",   GNT,           8'h00);
        chk("arst.VALID", {7'd0, VALID}, 8'h00);
        chk("arst.IDLE",  {7'd0, IDLE},  8'h01);
        chk("arst.A",     {5'd0, A},     8'h00);
        @(negedge CLK);
        RESET_L = 1'b1;
        REQ     = 8'h01;
        DONE    = 1'b0;
        push("arst_regrant", 8'h01, 3'd0, 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        pop_check();
        cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "arst_rel");
        cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "arst_gap");

        // Two-requester contention with DONE each grant
`ifdef ROUND_ROBIN_EN
        rr_a[0] = 3'd7; rr_a[1] = 3'd0; rr_a[2] = 3'd7; rr_a[3] = 3'd0;
`else
        rr_a[0] = 3'd7; rr_a[1] = 3'd7; rr_a[2] = 3'd7; rr_a[3] = 3'd7;
`endif
        for (int k = 0; k < 4; k++) begin
            gw = 8'h01 << rr_a[k];
            cyc(8'h81, 1'b0, gw,    rr_a[k], 1'b1, 1'b0, "rr_grant");
            cyc(8'h81, 1'b1, 8'h00, 3'd0,    1'b0, 1'b0, "rr_done");
            cyc(8'h81, 1'b0, 8'h00, 3'd0,    1'b0, 1'b0, "rr_gap");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
